trigger_event_capture: RTL and testbench
========================================

Name: trigger_event_capture

Overview:
- Consumer end of the discriminator trigger line.
- Watches the 1-bit hysteresis trigger and the 14-bit ADC stream, and builds one event record per trigger pulse: timestamp of rising edge, time-over-threshold (ToT) and peak amplitude.
- Presents records downstream over a valid/ready handshake, applies a programmable dead time, and counts triggers lost while busy.
- Sits between the discriminator and the readout FIFO/packetizer.

Parameters:
- DATA_W, 14, ADC sample width
- TS_W, 32, free-running timestamp width
- TOT_W, 16, ToT counter width
- ALIGN_DELAY, 2, pipeline stages applied to data so samples line up with trigger (discriminator latency = 2 cycles)
- DEAD_CYCLES, 16, dead-time cycles after each accepted record; 0 allowed
- LOST_W, 16, lost-trigger counter width

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data  input  DATA_W  raw ADC samples, same stream the discriminator sees
- trigger  input  1  discriminator output
- enable  input  1  arm capture; low = new pulses ignored
- ev_valid  output  1  event record available
- ev_ready  input  1  downstream accepts record
- ev_timestamp  output  TS_W  timestamp at trigger rising edge
- ev_tot  output  TOT_W  cycles trigger was high (saturating)
- ev_peak  output  DATA_W  max aligned sample during pulse
- ev_tot_ovf  output  1  ToT saturated
- lost_count  output  LOST_W  rising edges dropped while not IDLE (saturating)
- busy  output  1  state != IDLE

Behaviour:
- Only one clock domain; all registers update on posedge clk.
- Synchronous active-high reset. Reset values:
  - ev_valid, ev_tot_ovf, busy = 0
  - ev_timestamp, ev_tot, ev_peak, lost_count = 0
  - timestamp counter = 0; alignment pipeline = 0
  - trig_q = 1, so a trigger already high at reset release is not an event
  - state = IDLE
- Timestamp: free-running TS_W counter, +1 every cycle, wraps from all-ones to 0.
- Alignment: d_al = data delayed ALIGN_DELAY registers. ALIGN_DELAY = 0 means d_al = data.
- Edge detect: rise = trigger & ~trig_q; trig_q <= trigger every cycle.
- IDLE:
  - On rise & enable: latch timestamp, tot = 1, peak = d_al, ovf = 0 → PULSE.
  - On rise & ~enable: ignored, not counted as lost.
- PULSE:
  - While trigger = 1: tot += 1, saturating at 2^TOT_W-1 (ovf sets at saturation); peak = max(peak, d_al), unsigned compare.
  - On trigger = 0: copy timestamp/tot/peak/ovf to ev_* registers, assert ev_valid → OUTPUT. Falling-edge sample at cycle n gives ev_valid = 1 at cycle n+1.
  - enable dropping mid-pulse does not abort the event.
- OUTPUT:
  - ev_valid and all ev_* fields held stable until ev_valid & ev_ready.
  - On handshake: ev_valid = 0 next cycle → DEAD. If DEAD_CYCLES = 0, go directly to IDLE.
  - ev_ready asserted before ev_valid has no effect.
- DEAD: count DEAD_CYCLES cycles, then → IDLE. First cycle in IDLE can accept a rise.
- Lost triggers: rise in OUTPUT or DEAD (any enable) → lost_count += 1, saturating at 2^LOST_W-1. A trigger still high on entry to IDLE is not a rise and is not captured.
- ev_* fields retain the last record after handshake; they are only meaningful while ev_valid = 1.
- Reset mid-operation (any state): immediate return to reset values next cycle; any pending record is discarded.
- Timestamp wrap inside a pulse has no effect on ToT; timestamp is latched once at the rise.

Test Plan:
- Basic event: ALIGN_DELAY = 2, rise when ts = 100, trigger high 5 cycles, aligned samples 10, 500, 900, 700, 20, ev_ready = 1 → ev_valid one cycle after the trigger-low sample, ev_timestamp = 100, ev_tot = 5, ev_peak = 900, ev_tot_ovf = 0; busy low 16 cycles after handshake.
- Backpressure: ev_ready = 0 for 20 cycles, second trigger pulse during the hold → fields stay constant, lost_count = 1; after ev_ready = 1, one handshake only.
- Dead time: DEAD_CYCLES = 16, second rise 10 cycles after handshake → lost_count += 1; rise 17 cycles after handshake → captured normally.
- Saturation: TOT_W = 4, trigger high 20 cycles → ev_tot = 15, ev_tot_ovf = 1. LOST_W = 2, 5 lost rises → lost_count = 3.
- Enable / reset edges: enable = 0 on rise → no event, lost_count unchanged. Enable falls mid-pulse → event still reported. Trigger high during rst release → no event until trigger falls and rises again.
- Reset mid-OUTPUT: rst pulse while ev_valid = 1 → ev_valid = 0, lost_count = 0, ts = 0 the cycle after rst; next pulse captured with the new timestamp.

Source files
------------

// File: rtl/trigger_event_capture.sv
// trigger_event_capture: builds one timestamp/ToT/peak record per trigger pulse,
// hands it downstream over valid/ready, then holds off for a dead time.
module trigger_event_capture #(
   parameter int DATA_W      = 14,
   parameter int TS_W        = 32,
   parameter int TOT_W       = 16,
   parameter int ALIGN_DELAY = 2,
   parameter int DEAD_CYCLES = 16,
   parameter int LOST_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data,
   input  logic              trigger,
   input  logic              enable,
   output logic              ev_valid,
   input  logic              ev_ready,
   output logic [TS_W-1:0]   ev_timestamp,
   output logic [TOT_W-1:0]  ev_tot,
   output logic [DATA_W-1:0] ev_peak,
   output logic              ev_tot_ovf,
   output logic [LOST_W-1:0] lost_count,
   output logic              busy
);
   localparam int DC_W = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_OUTPUT, S_DEAD} state_t;
   state_t              r_state;
   logic [TS_W-1:0]     r_ts;
   logic [TS_W-1:0]     r_cap_ts;
   logic [TOT_W-1:0]    r_tot;
   logic [DATA_W-1:0]   r_peak;
   logic                r_ovf;
   logic                r_trig_q;
   logic [DC_W-1:0]     r_dead;
   logic [DATA_W-1:0]   w_d_al;
   logic                w_rise;
   // Delay samples by the discriminator latency so the peak search sees the pulse itself
   generate
      if (ALIGN_DELAY == 0) begin : g_nodly
         assign w_d_al = data;
      end else begin : g_dly
         logic [DATA_W-1:0] r_pipe [ALIGN_DELAY];
         always_ff @(posedge clk) begin
            r_pipe[0] <= rst ? '0 : data;
            for (int k = 1; k < ALIGN_DELAY; k++) r_pipe[k] <= rst ? '0 : r_pipe[k-1];
         end
         assign w_d_al = r_pipe[ALIGN_DELAY-1];
      end
   endgenerate
   assign w_rise = trigger & ~r_trig_q;
   assign busy   = r_state != S_IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ts         <= '0;
         r_cap_ts     <= '0;
         r_tot        <= '0;
         r_peak       <= '0;
         r_ovf        <= 1'b0;
         r_trig_q     <= 1'b1;
         r_dead       <= '0;
         ev_valid     <= 1'b0;
         ev_timestamp <= '0;
         ev_tot       <= '0;
         ev_peak      <= '0;
         ev_tot_ovf   <= 1'b0;
         lost_count   <= '0;
      end else begin
         r_ts     <= r_ts + 1'b1;
         r_trig_q <= trigger;
         if (w_rise && (r_state == S_OUTPUT || r_state == S_DEAD) && !(&lost_count))
            lost_count <= lost_count + 1'b1;
         case (r_state)
            S_IDLE: if (w_rise && enable) begin
               r_cap_ts <= r_ts;
               r_tot    <= TOT_W'(1);
               r_peak   <= w_d_al;
               r_ovf    <= 1'b0;
               r_state  <= S_PULSE;
            end
            S_PULSE: if (trigger) begin
               if (&r_tot) r_ovf <= 1'b1;
               else r_tot <= r_tot + 1'b1;
               if (w_d_al > r_peak) r_peak <= w_d_al;
            end else begin
               ev_timestamp <= r_cap_ts;
               ev_tot       <= r_tot;
               ev_peak      <= r_peak;
               ev_tot_ovf   <= r_ovf;
               ev_valid     <= 1'b1;
               r_state      <= S_OUTPUT;
            end
            S_OUTPUT: if (ev_ready) begin
               ev_valid <= 1'b0;
               r_dead   <= DC_W'(DEAD_CYCLES - 1);
               r_state  <= DEAD_CYCLES == 0 ? S_IDLE : S_DEAD;
            end
            S_DEAD: if (r_dead == '0) r_state <= S_IDLE;
                    else r_dead <= r_dead - 1'b1;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_trigger_event_capture.sv
// tb_trigger_event_capture: table-driven pulses scored through a queue, plus
// hand-written backpressure, dead-time, enable, reset and saturation sequences.
module tb_trigger_event_capture;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] data = '0;
   logic        trigger = 1'b0, enable = 1'b1, ev_ready = 1'b1;
   logic        ev_valid, ev_tot_ovf, busy;
   logic [31:0] ev_timestamp;
   logic [15:0] ev_tot, lost_count;
   logic [13:0] ev_peak;
   logic [13:0] d2 = '0;
   logic        t2 = 1'b0, en2 = 1'b1, rdy2 = 1'b0;
   logic        v2, ovf2, busy2;
   logic [31:0] ts2;
   logic [3:0]  tot2;
   logic [13:0] pk2;
   logic [1:0]  lost2;
   int          errors = 0, checks = 0, hs_cnt = 0;
   logic [31:0] tb_ts = '0;
   typedef struct {logic [31:0] ts; logic [15:0] tot; logic [13:0] peak; logic ovf;} rec_t;
   typedef struct {int len; logic [13:0] s[8]; logic [15:0] tot; logic [13:0] peak;} vec_t;
   rec_t        sb[$];
   vec_t        vt[6];

   always #5 clk = ~clk;

   trigger_event_capture dut (
      .clk(clk), .rst(rst), .data(data), .trigger(trigger), .enable(enable),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_timestamp(ev_timestamp),
      .ev_tot(ev_tot), .ev_peak(ev_peak), .ev_tot_ovf(ev_tot_ovf),
      .lost_count(lost_count), .busy(busy));

   trigger_event_capture #(.TOT_W(4), .LOST_W(2), .DEAD_CYCLES(0), .ALIGN_DELAY(0)) dut2 (
      .clk(clk), .rst(rst), .data(d2), .trigger(t2), .enable(en2),
      .ev_valid(v2), .ev_ready(rdy2), .ev_timestamp(ts2),
      .ev_tot(tot2), .ev_peak(pk2), .ev_tot_ovf(ovf2),
      .lost_count(lost2), .busy(busy2));

   always @(posedge clk) tb_ts <= rst ? 32'd0 : tb_ts + 32'd1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_pulse(input int len, input logic [13:0] s[8], input bit push,
                            input logic [15:0] etot, input logic [13:0] epk, input int en_off = -99);
      for (int i = -2; i <= len; i++) begin
         data    = (i + 2 >= 0 && i + 2 < len && i + 2 < 8) ? s[i+2] : 14'd0;
         trigger = (i >= 0 && i < len);
         if (i == en_off) enable = 1'b0;
         if (i == 0 && push) sb.push_back('{tb_ts, etot, epk, 1'b0});
         tick;
      end
      data = '0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 100) begin
         tick;
         n++;
      end
      chk(nm, {63'd0, busy}, 64'd0);
   endtask

   always @(negedge clk) begin : mon
      rec_t e;
      if (!rst && ev_valid && ev_ready) begin
         hs_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got ts=%0d expected no record", ev_timestamp);
         end else begin
            e = sb.pop_front();
            chk("sb_timestamp", ev_timestamp, e.ts);
            chk("sb_tot", ev_tot, e.tot);
            chk("sb_peak", ev_peak, e.peak);
            chk("sb_ovf", ev_tot_ovf, e.ovf);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rec_t bp;
      int   n, hs0;
      logic [13:0] s[8];
      vt[0] = '{5, '{14'd10, 14'd500, 14'd900, 14'd700, 14'd20, 14'd0, 14'd0, 14'd0}, 16'd5, 14'd900};
      vt[1] = '{1, '{14'd42, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0}, 16'd1, 14'd42};
      vt[2] = '{3, '{14'd16383, 14'd0, 14'd5, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0}, 16'd3, 14'd16383};
      vt[3] = '{4, '{14'd7, 14'd7, 14'd7, 14'd8, 14'd0, 14'd0, 14'd0, 14'd0}, 16'd4, 14'd8};
      vt[4] = '{2, '{14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0}, 16'd2, 14'd0};
      vt[5] = '{6, '{14'd100, 14'd200, 14'd300, 14'd400, 14'd500, 14'd16000, 14'd0, 14'd0}, 16'd6, 14'd16000};
      s = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd0, 14'd0, 14'd0, 14'd0};

      repeat (3) tick;
      chk("rst_valid", ev_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_lost", lost_count, 0);
      chk("rst_fields", {ev_timestamp, ev_tot, ev_peak, ev_tot_ovf}, 0);
      rst = 1'b0;
      tick;

      n = 0;
      while (tb_ts != 32'd98 && n < 200) begin
         tick;
         n++;
      end
      run_pulse(vt[0].len, vt[0].s, 1'b1, vt[0].tot, vt[0].peak);
      chk("basic_valid", ev_valid, 1);
      chk("basic_ts", ev_timestamp, 100);
      chk("basic_tot", ev_tot, 5);
      chk("basic_peak", ev_peak, 900);
      n = 0;
      while (busy && n < 100) begin
         tick;
         n++;
      end
      chk("basic_dead_len", n, 17);

      for (int k = 1; k < 6; k++) begin
         run_pulse(vt[k].len, vt[k].s, 1'b1, vt[k].tot, vt[k].peak);
         chk($sformatf("vec%0d_valid", k), ev_valid, 1);
         wait_idle($sformatf("vec%0d_idle", k));
      end

      ev_ready = 1'b0;
      run_pulse(4, s, 1'b1, 16'd4, 14'd4);
      bp = sb[0];
      for (int c = 0; c < 20; c++) begin
         if (c == 3) trigger = 1'b1;
         if (c == 5) trigger = 1'b0;
         tick;
         chk("bp_hold", {ev_valid, ev_timestamp, ev_tot, ev_peak},
             {1'b1, bp.ts, bp.tot, bp.peak});
      end
      chk("bp_lost", lost_count, 1);
      hs0 = hs_cnt;
      ev_ready = 1'b1;
      repeat (3) tick;
      chk("bp_one_handshake", hs_cnt - hs0, 1);
      chk("bp_valid_low", ev_valid, 0);
      wait_idle("bp_idle");

      run_pulse(2, s, 1'b1, 16'd2, 14'd2);
      repeat (10) tick;
      trigger = 1'b1;
      repeat (2) tick;
      trigger = 1'b0;
      chk("dead_lost", lost_count, 2);
      chk("dead_busy", busy, 1);
      repeat (3) tick;
      run_pulse(3, s, 1'b1, 16'd3, 14'd3);
      chk("dead_after_valid", ev_valid, 1);
      chk("dead_after_lost", lost_count, 2);
      wait_idle("dead_idle");

      hs0 = hs_cnt;
      enable = 1'b0;
      run_pulse(3, s, 1'b0, 16'd0, 14'd0);
      repeat (3) tick;
      chk("en_off_busy", busy, 0);
      chk("en_off_lost", lost_count, 2);
      chk("en_off_no_event", hs_cnt - hs0, 0);
      enable = 1'b1;
      s = '{14'd3, 14'd9, 14'd4, 14'd1, 14'd0, 14'd0, 14'd0, 14'd0};
      run_pulse(4, s, 1'b1, 16'd4, 14'd9, 2);
      chk("en_fall_valid", ev_valid, 1);
      enable = 1'b1;
      wait_idle("en_fall_idle");

      trigger = 1'b1;
      rst = 1'b1;
      repeat (2) tick;
      rst = 1'b0;
      repeat (5) tick;
      chk("rst_trig_busy", busy, 0);
      chk("rst_trig_valid", ev_valid, 0);
      trigger = 1'b0;
      tick;
      run_pulse(2, s, 1'b1, 16'd2, 14'd9);
      chk("rst_trig_capture", ev_valid, 1);
      wait_idle("rst_trig_idle");

      ev_ready = 1'b0;
      run_pulse(3, s, 1'b1, 16'd3, 14'd9);
      chk("rmid_valid", ev_valid, 1);
      trigger = 1'b1;
      tick;
      trigger = 1'b0;
      tick;
      chk("rmid_lost_pre", lost_count, 1);
      rst = 1'b1;
      sb.delete();
      tick;
      chk("rmid_valid_clr", ev_valid, 0);
      chk("rmid_lost_clr", lost_count, 0);
      chk("rmid_busy_clr", busy, 0);
      rst = 1'b0;
      run_pulse(3, s, 1'b1, 16'd3, 14'd9);
      chk("rmid_new_ts", ev_timestamp, 2);
      ev_ready = 1'b1;
      wait_idle("rmid_idle");

      for (int i = 0; i < 20; i++) begin
         t2 = 1'b1;
         d2 = 14'(i * 37);
         tick;
      end
      t2 = 1'b0;
      d2 = '0;
      tick;
      chk("sat_valid", v2, 1);
      chk("sat_tot", tot2, 15);
      chk("sat_ovf", ovf2, 1);
      chk("sat_peak", pk2, 703);
      for (int i = 0; i < 5; i++) begin
         t2 = 1'b1;
         tick;
         t2 = 1'b0;
         tick;
      end
      chk("sat_lost", lost2, 3);
      rdy2 = 1'b1;
      tick;
      chk("nodead_valid", v2, 0);
      chk("nodead_busy", busy2, 0);
      rdy2 = 1'b0;
      t2 = 1'b1;
      d2 = 14'd5;
      repeat (3) tick;
      t2 = 1'b0;
      tick;
      chk("short_tot", tot2, 3);
      chk("short_ovf", ovf2, 0);
      rdy2 = 1'b1;
      repeat (5) tick;
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
